bit_serializer: RTL

- Parallel-in, serial-out stage that sits directly upstream of the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on serial_out, which drives the detector's serial input.
- A one-word holding buffer lets back-to-back words stream with no idle gap.
- bit_valid marks the cycles that carry real data, so downstream logic can qualify or gate on it.

---
 rtl/bit_serializer_pkg.sv | 13 +
 rtl/bit_serializer_if.sv | 14 +
 rtl/bit_serializer_word_hold_reg.sv | 45 ++++
 rtl/bit_serializer.sv | 107 ++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serial link: shifter states and default word format.
// Kept separate so a future deserializer can reuse the same state encoding.
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int   DEFAULT_WIDTH    = 8;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer_if.sv
// Parallel word handshake into the serializer: data_in qualified by data_valid,
// transferred on any rising edge where data_valid and data_ready are both high.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_in, output data_valid, input  data_ready);
  modport slave  (input  data_in, input  data_valid, output data_ready);

endinterface : bit_serializer_if

// File: rtl/bit_serializer_word_hold_reg.sv
// One-entry word buffer that parks the next word while the shifter is busy.
// Its full flag alone decides whether the serializer can take another word.
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             ready
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = data_in;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) full_q <= 1'b0;
    else          full_q <= full_d;
  end

  // NOTE: the data register has no reset; full_q is what marks it valid, so
  // clearing the flag alone empties the buffer.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data_out = data_q;
  assign full     = full_q;
  assign ready    = !full_q;

endmodule : word_hold_reg

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage: one WIDTH-bit word in, WIDTH serial bits out,
// with a one-word holding buffer so consecutive words stream without a gap.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bit_serializer_if.slave      in_if,
  output logic                 serial_out,
  output logic                 bit_valid,
  output logic                 frame_start,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic             hold_full;
  logic             hold_ready;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             last_bit;
  logic             load_new;
  logic             load_hold;
  logic             park_word;

  assign accept    = in_if.data_valid && hold_ready;
  assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == LAST_CNT);
  // Reload from the buffer wins on the last bit; data_ready is low then anyway.
  assign load_hold = last_bit && hold_full;
  assign load_new  = accept && ((state_q == IDLE) || (last_bit && !hold_full));
  assign park_word = accept && (state_q == SHIFT) && !last_bit;

  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (park_word),
    .unload   (load_hold),
    .data_in  (in_if.data_in),
    .data_out (hold_data),
    .full     (hold_full),
    .ready    (hold_ready)
  );

  assign in_if.data_ready = hold_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // NOTE: every variable gets a default before any branch, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit && !load_hold && !load_new) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (load_new) begin
      shift_d   = in_if.data_in;
      bit_cnt_d = '0;
    end else if (load_hold) begin
      shift_d   = hold_data;
      bit_cnt_d = '0;
    end else if (last_bit) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (state_q == SHIFT) begin
      shift_d   = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  // Outputs come only from registered state; data_in never reaches serial_out directly.
  always_comb begin
    bit_valid   = (state_q == SHIFT);
    frame_start = (state_q == SHIFT) && (bit_cnt_q == '0);
    busy        = (state_q == SHIFT) || hold_full;
    serial_out  = IDLE_BIT;
    if (state_q == SHIFT) serial_out = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  end

endmodule : bit_serializer
